main_memory_controller: RTL and testbench

//  Line-granular main-memory model and controller sitting directly below the data

---
 rtl/main_memory_controller.sv | 90 +++++++++
 tb/tb_main_memory_controller.sv | 101 ++++++++++
 2 files changed

// File: rtl/main_memory_controller.sv
// main_memory_controller: fixed-latency line-granular backing store servicing cache fills and write-backs
module main_memory_controller #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int DEPTH_LINES    = 1024,
  parameter int LATENCY        = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mem_req,
  input  logic                             mem_we,
  input  logic [ADDR_W-1:0]                mem_addr,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] mem_wdata,
  output logic [DATA_W*WORDS_PER_LINE-1:0] mem_rdata,
  output logic                             mem_ready,
  output logic                             mem_busy
);
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;
  localparam int IDX_W  = $clog2(DEPTH_LINES);
  localparam int OFF_W  = 2 + $clog2(WORDS_PER_LINE);
  localparam int CNT_W  = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef logic [LINE_W-1:0] mem_t [DEPTH_LINES];
  function automatic mem_t init_mem();
    mem_t m;
    for (int l = 0; l < DEPTH_LINES; l++)
      for (int w = 0; w < WORDS_PER_LINE; w++)
        m[l][w*DATA_W +: DATA_W] = DATA_W'(l * WORDS_PER_LINE + w);
    return m;
  endfunction
  mem_t mem_q = init_mem();
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] line_q, line_d;
  logic we_q, we_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic commit_wr;
  logic unused_addr;
  assign unused_addr = ^{mem_addr[ADDR_W-1:OFF_W+IDX_W], mem_addr[OFF_W-1:0]};
  assign commit_wr = (state_q == WAIT) && (cnt_q == '0) && we_q;
  assign mem_rdata = rdata_q;
  assign mem_ready = (state_q == DONE);
  assign mem_busy  = (state_q != IDLE);
  // Next-state logic: latch the request in IDLE, count down in WAIT, commit the read on the last WAIT cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (mem_req) begin
        state_d = WAIT;
        cnt_d   = CNT_W'(LATENCY - 1);
        line_d  = mem_addr[OFF_W +: IDX_W];
        we_d    = mem_we;
        wdata_d = mem_wdata;
      end
      WAIT: if (cnt_q == '0) begin
        state_d = DONE;
        rdata_d = we_q ? rdata_q : mem_q[line_q];
      end else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // Control and output registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // Backing store survives reset; a write lands only when the access reaches its commit cycle
  always_ff @(posedge clk) begin
    if (!reset && commit_wr) mem_q[line_q] <= wdata_q;
  end
endmodule

// File: tb/tb_main_memory_controller.sv
// tb_main_memory_controller: scoreboard bench for fill/write-back latency, data, aliasing, busy-ignore and reset abort
module tb_main_memory_controller;
  localparam int LAT = 10;
  localparam int DEPTH = 1024;
  logic clk = 0;
  logic reset = 1;
  logic mem_req = 0;
  logic mem_we = 0;
  logic [31:0] mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic mem_ready, mem_busy;
  int errors = 0;
  int checks = 0;
  logic [127:0] sb [$];
  logic [127:0] model [int];
  logic [127:0] last_rd = '0;
  main_memory_controller #(.LATENCY(LAT), .DEPTH_LINES(DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_busy(mem_busy)
  );
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] rd_line(input int l);
    logic [127:0] v;
    if (model.exists(l)) return model[l];
    for (int w = 0; w < 4; w++) v[w*32 +: 32] = 32'(l * 4 + w);
    return v;
  endfunction
  task automatic run(input logic we, input logic [31:0] addr, input logic [127:0] wd, input bit disturb, input int abort_at);
    int n, busy_n, l;
    l = int'((addr >> 4) % DEPTH);
    @(negedge clk);
    mem_req = 1; mem_we = we; mem_addr = addr; mem_wdata = wd;
    if (!we) sb.push_back(rd_line(l));
    @(negedge clk);
    mem_req = 0; mem_addr = $urandom; mem_wdata = {4{$urandom}};
    n = 0; busy_n = 0;
    while (!mem_ready && n < 40) begin
      busy_n += int'(mem_busy);
      if (disturb && n == 3) begin mem_req = 1; mem_we = 1; mem_addr = 32'h30; mem_wdata = '1; end
      if (disturb && n == 5) mem_req = 0;
      if (n == abort_at) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("abort_busy", {127'd0, mem_busy}, 128'd0);
        chk("abort_ready", {127'd0, mem_ready}, 128'd0);
        chk("abort_rdata", mem_rdata, 128'd0);
        last_rd = '0;
        if (!we) void'(sb.pop_back());
        return;
      end
      @(negedge clk);
      n++;
    end
    busy_n += int'(mem_busy);
    chk("latency", 128'(n), 128'(LAT));
    chk("busy_cycles", 128'(busy_n), 128'(LAT + 1));
    if (!we) begin
      last_rd = sb.pop_front();
      chk("rdata", mem_rdata, last_rd);
    end else begin
      model[l] = wd;
      chk("rdata_hold", mem_rdata, last_rd);
    end
    @(negedge clk);
    chk("ready_pulse", {127'd0, mem_ready}, 128'd0);
    chk("idle_busy", {127'd0, mem_busy}, 128'd0);
  endtask
  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset_ready", {127'd0, mem_ready}, 128'd0);
    chk("reset_busy", {127'd0, mem_busy}, 128'd0);
    chk("reset_rdata", mem_rdata, 128'd0);
    run(0, 32'h10, '0, 0, -1);
    chk("fill_line1", mem_rdata, {32'd7, 32'd6, 32'd5, 32'd4});
    run(1, 32'h20, {32'hD, 32'hC, 32'hB, 32'hA}, 0, -1);
    run(0, 32'h24, '0, 0, -1);
    chk("fill_line2", mem_rdata, {32'hD, 32'hC, 32'hB, 32'hA});
    run(0, 32'h10 + DEPTH * 16, '0, 0, -1);
    chk("wrap_line1", mem_rdata, {32'd7, 32'd6, 32'd5, 32'd4});
    run(0, 32'h14, '0, 1, -1);
    run(1, 32'h30, {4{32'hDEAD_BEEF}}, 0, 4);
    run(0, 32'h3C, '0, 0, -1);
    chk("abort_no_commit", mem_rdata, {32'd15, 32'd14, 32'd13, 32'd12});
    run(1, 32'h50, {32'h44, 32'h33, 32'h22, 32'h11}, 0, -1);
    run(0, 32'h50, '0, 0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
